sp3_frame_packer: RTL and testbench

SP3_FRAME_PACKER -- requirements
Module: sp3_frame_packer

---
 rtl/sp3_packer_pkg.sv | 21 ++
 rtl/sp3_sat_counter.sv | 30 +++
 rtl/sp3_frame_packer.sv | 184 ++++++++++++++++++
 tb/tb_sp3_frame_packer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp3_packer_pkg.sv
// Shared constants, header tags and FSM state type for the SP3 uplink frame packer.
package sp3_packer_pkg;

  localparam int         FRAME_W      = 234;
  localparam int         WORDS_PER_CH = 9;
  localparam logic [3:0] TAG_A        = 4'hA;
  localparam logic [3:0] TAG_B        = 4'hB;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_A = 2'd1,
    SEND_B = 2'd2
  } state_e;

  function automatic logic [31:0] make_header(input logic [3:0]  tag,
                                              input logic        fec,
                                              input logic [15:0] cnt);
    return {tag, fec, 11'b0, cnt};
  endfunction

endpackage

// File: rtl/sp3_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sp3_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/sp3_frame_packer.sv
// Packs latched A/B uplink frames into 9-word sub-packets on a valid/ready stream.
// Optional FEC-corrected frame counters are built when SP3_FRAME_PACKER_FEC_CNT_EN is defined.
module sp3_frame_packer #(
  parameter int FRAME_W = sp3_packer_pkg::FRAME_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk20,
  input  logic               reset,
  input  logic [FRAME_W-1:0] frame_a_i,
  input  logic [FRAME_W-1:0] frame_b_i,
  input  logic               rdy_a_i,
  input  logic               rdy_b_i,
  input  logic               fec_a_i,
  input  logic               fec_b_i,
  input  logic               enable_i,
  input  logic [1:0]         chan_mask_i,
  output logic [31:0]        m_data_o,
  output logic               m_valid_o,
  output logic               m_last_o,
  input  logic               m_ready_i,
  output logic               busy_o,
  output logic [CNT_W-1:0]   frame_cnt_o,
  output logic [CNT_W-1:0]   drop_cnt_o,
  output logic [CNT_W-1:0]   fec_cnt_a_o,
  output logic [CNT_W-1:0]   fec_cnt_b_o
);

  import sp3_packer_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(WORDS_PER_CH - 1);
  localparam int         PAD_W    = 32 * (WORDS_PER_CH - 1);

  state_e               state_q, state_d;
  logic [3:0]           widx_q, widx_d;
  logic [FRAME_W-1:0]   frame_a_q, frame_a_d;
  logic [FRAME_W-1:0]   frame_b_q, frame_b_d;
  logic                 fec_a_q, fec_a_d;
  logic                 fec_b_q, fec_b_d;
  logic                 incl_b_q, incl_b_d;
  logic [CNT_W-1:0]     cnt_lat_q, cnt_lat_d;
  logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;

  logic [1:0]           incl_now;
  logic                 cap_cond;
  logic                 handshake;
  logic [15:0]          cnt16;
  logic [FRAME_W-1:0]   sel_frame;
  logic                 sel_fec;
  logic [3:0]           sel_tag;
  logic [PAD_W-1:0]     frame_pad;
  logic [2:0]           word_k;

  // Only channels that are both masked in and ready this cycle join the packet.
  assign incl_now  = chan_mask_i & {rdy_b_i, rdy_a_i};
  assign cap_cond  = enable_i && (incl_now != 2'b00);
  assign handshake = m_valid_o && m_ready_i;

  assign m_valid_o = (state_q != IDLE);
  assign busy_o    = (state_q != IDLE);

  generate
    if (CNT_W >= 16) begin : g_cnt_trunc
      assign cnt16 = cnt_lat_q[15:0];
    end else begin : g_cnt_ext
      assign cnt16 = {{(16-CNT_W){1'b0}}, cnt_lat_q};
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    widx_d      = widx_q;
    frame_a_d   = frame_a_q;
    frame_b_d   = frame_b_q;
    fec_a_d     = fec_a_q;
    fec_b_d     = fec_b_q;
    incl_b_d    = incl_b_q;
    cnt_lat_d   = cnt_lat_q;
    frame_cnt_d = frame_cnt_q + CNT_W'(rdy_a_i | rdy_b_i);
    case (state_q)
      IDLE: begin
        if (cap_cond) begin
          frame_a_d = frame_a_i;
          frame_b_d = frame_b_i;
          fec_a_d   = fec_a_i;
          fec_b_d   = fec_b_i;
          incl_b_d  = incl_now[1];
          cnt_lat_d = frame_cnt_q;
          widx_d    = '0;
          state_d   = incl_now[0] ? SEND_A : SEND_B;
        end
      end
      SEND_A, SEND_B: begin
        if (handshake) begin
          if (widx_q == LAST_IDX) begin
            widx_d  = '0;
            state_d = (state_q == SEND_A && incl_b_q) ? SEND_B : IDLE;
          end else begin
            widx_d = widx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output word is purely a function of latched state, so it holds while stalled.
  always_comb begin
    sel_frame = frame_a_q;
    sel_fec   = fec_a_q;
    sel_tag   = TAG_A;
    if (state_q == SEND_B) begin
      sel_frame = frame_b_q;
      sel_fec   = fec_b_q;
      sel_tag   = TAG_B;
    end
    frame_pad                = '0;
    frame_pad[FRAME_W-1:0]   = sel_frame;
    word_k                   = 3'(widx_q - 4'd1);
    m_data_o                 = '0;
    if (state_q != IDLE) begin
      if (widx_q == 4'd0) begin
        m_data_o = make_header(sel_tag, sel_fec, cnt16);
      end else begin
        m_data_o = frame_pad[{word_k, 5'b00000} +: 32];
      end
    end
    m_last_o = (state_q != IDLE) && (widx_q == LAST_IDX) &&
               ((state_q == SEND_B) || !incl_b_q);
  end

  always_ff @(posedge clk20) begin
    if (reset) begin
      state_q     <= IDLE;
      widx_q      <= '0;
      frame_a_q   <= '0;
      frame_b_q   <= '0;
      fec_a_q     <= 1'b0;
      fec_b_q     <= 1'b0;
      incl_b_q    <= 1'b0;
      cnt_lat_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      widx_q      <= widx_d;
      frame_a_q   <= frame_a_d;
      frame_b_q   <= frame_b_d;
      fec_a_q     <= fec_a_d;
      fec_b_q     <= fec_b_d;
      incl_b_q    <= incl_b_d;
      cnt_lat_q   <= cnt_lat_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt_o = frame_cnt_q;

  // A capture request that arrives while a packet is in flight is lost.
  sp3_sat_counter #(.WIDTH(CNT_W)) u_drop_cnt (
    .clk     (clk20),
    .clear   (reset),
    .inc     ((state_q != IDLE) && cap_cond),
    .count_o (drop_cnt_o)
  );

`ifdef SP3_FRAME_PACKER_FEC_CNT_EN
  sp3_sat_counter #(.WIDTH(CNT_W)) u_fec_cnt_a (
    .clk     (clk20),
    .clear   (reset),
    .inc     (fec_a_i && rdy_a_i),
    .count_o (fec_cnt_a_o)
  );

  sp3_sat_counter #(.WIDTH(CNT_W)) u_fec_cnt_b (
    .clk     (clk20),
    .clear   (reset),
    .inc     (fec_b_i && rdy_b_i),
    .count_o (fec_cnt_b_o)
  );
`else
  assign fec_cnt_a_o = '0;
  assign fec_cnt_b_o = '0;
`endif

endmodule

// File: tb/tb_sp3_frame_packer.sv
// Scoreboard bench for sp3_frame_packer: stimulus pushes expected words, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_sp3_frame_packer;

  localparam int FRAME_W = 234;
  localparam int CNT_W   = 10;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk20 = 1'b0;
  logic               reset;
  logic [FRAME_W-1:0] frame_a_i, frame_b_i;
  logic               rdy_a_i, rdy_b_i, fec_a_i, fec_b_i, enable_i;
  logic [1:0]         chan_mask_i;
  logic [31:0]        m_data_o;
  logic               m_valid_o, m_last_o, m_ready_i, busy_o;
  logic [CNT_W-1:0]   frame_cnt_o, drop_cnt_o, fec_cnt_a_o, fec_cnt_b_o;

  always #5 clk20 = ~clk20;

  sp3_frame_packer #(.FRAME_W(FRAME_W), .CNT_W(CNT_W)) dut (
    .clk20       (clk20),
    .reset       (reset),
    .frame_a_i   (frame_a_i),
    .frame_b_i   (frame_b_i),
    .rdy_a_i     (rdy_a_i),
    .rdy_b_i     (rdy_b_i),
    .fec_a_i     (fec_a_i),
    .fec_b_i     (fec_b_i),
    .enable_i    (enable_i),
    .chan_mask_i (chan_mask_i),
    .m_data_o    (m_data_o),
    .m_valid_o   (m_valid_o),
    .m_last_o    (m_last_o),
    .m_ready_i   (m_ready_i),
    .busy_o      (busy_o),
    .frame_cnt_o (frame_cnt_o),
    .drop_cnt_o  (drop_cnt_o),
    .fec_cnt_a_o (fec_cnt_a_o),
    .fec_cnt_b_o (fec_cnt_b_o)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_words = 0;
  int   fc = 0;
  int   dc = 0;
  logic [31:0] held_data;
  logic        held_last;
  bit          stalled = 1'b0;

  // B-only packet with incrementing bytes, count 1: hand-computed words.
  logic [31:0] t3_exp [9] = '{32'hB0000001, 32'h03020100, 32'h07060504, 32'h0B0A0908,
                              32'h0F0E0D0C, 32'h13121110, 32'h17161514, 32'h1B1A1918,
                              32'h0000011C};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, got, want);
    end
  endtask

  function automatic logic [FRAME_W-1:0] make_frame(input logic [31:0] seed);
    logic [255:0] t;
    for (int k = 0; k < 8; k++) t[32*k +: 32] = seed + 32'(k) * 32'h01020304;
    return t[FRAME_W-1:0];
  endfunction

  function automatic logic [31:0] frame_word(input logic [FRAME_W-1:0] f, input int k);
    logic [255:0] t;
    t = '0;
    t[FRAME_W-1:0] = f;
    return t[32*k +: 32];
  endfunction

  task automatic push_ch(input logic [3:0] tag, input logic fec, input logic [FRAME_W-1:0] f,
                         input int cnt, input logic last_ch);
    exp_t e;
    e.data = {tag, fec, 11'b0, 16'(cnt)};
    e.last = 1'b0;
    sb.push_back(e);
    for (int k = 0; k < 8; k++) begin
      e.data = frame_word(f, k);
      e.last = last_ch && (k == 7);
      sb.push_back(e);
    end
  endtask

  task automatic push_pkt(input logic [1:0] incl, input int cnt);
    if (incl[0]) push_ch(4'hA, fec_a_i, frame_a_i, cnt, !incl[1]);
    if (incl[1]) push_ch(4'hB, fec_b_i, frame_b_i, cnt, 1'b1);
  endtask

  // One clock; the frame-count model follows the rdy inputs of the cycle.
  task automatic cycle();
    if (rdy_a_i || rdy_b_i) fc = (fc + 1) & CNT_MAX;
    @(posedge clk20);
    #1;
  endtask

  task automatic capture(input logic [1:0] mask, input logic ra, input logic rb, input bit do_push);
    chan_mask_i = mask;
    rdy_a_i     = ra;
    rdy_b_i     = rb;
    enable_i    = 1'b1;
    if (do_push) push_pkt(mask & {rb, ra}, fc);
    cycle();
    rdy_a_i     = 1'b0;
    rdy_b_i     = 1'b0;
    enable_i    = 1'b0;
    chan_mask_i = 2'b00;
    frame_a_i   = ~frame_a_i;
    frame_b_i   = ~frame_b_i;
  endtask

  task automatic drain(input bit rnd);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 4000) begin
      cycle();
      n++;
      if (rnd) m_ready_i = 1'($urandom_range(0, 1));
    end
    m_ready_i = 1'b1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d words outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic cont(input int k_pk);
    chan_mask_i = 2'b11;
    enable_i    = 1'b1;
    rdy_a_i     = 1'b1;
    rdy_b_i     = 1'b1;
    for (int n = 0; n < k_pk; n++) begin
      frame_a_i = make_frame(32'h1000_0000 + 32'(n));
      frame_b_i = make_frame(32'h2000_0000 + 32'(n));
      push_pkt(2'b11, fc);
      repeat (19) cycle();
    end
    rdy_a_i     = 1'b0;
    rdy_b_i     = 1'b0;
    enable_i    = 1'b0;
    chan_mask_i = 2'b00;
    dc = (dc + 18 * k_pk > CNT_MAX) ? CNT_MAX : dc + 18 * k_pk;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_valid"}, 32'(m_valid_o), 32'd0);
    check({tag, "_last"},  32'(m_last_o),  32'd0);
    check({tag, "_data"},  m_data_o,       32'd0);
    check({tag, "_busy"},  32'(busy_o),    32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt_o), 32'd0);
    check({tag, "_drop_cnt"},  32'(drop_cnt_o),  32'd0);
    check({tag, "_fec_a"},     32'(fec_cnt_a_o), 32'd0);
    check({tag, "_fec_b"},     32'(fec_cnt_b_o), 32'd0);
  endtask

  always @(negedge clk20) begin
    if (reset) begin
      stalled = 1'b0;
    end else if (m_valid_o) begin
      if (stalled) begin
        n_cmp++;
        if (m_data_o !== held_data || m_last_o !== held_last) begin
          n_bad++;
          $display("FAIL stall_hold: got 0x%08h last %b, required 0x%08h last %b",
                   m_data_o, m_last_o, held_data, held_last);
        end
      end
      if (m_ready_i) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL extra_word: got 0x%08h last %b, required no word", m_data_o, m_last_o);
        end else begin
          mon_e = sb.pop_front();
          n_words++;
          if (m_data_o !== mon_e.data || m_last_o !== mon_e.last) begin
            n_bad++;
            $display("FAIL word: got 0x%08h last %b, required 0x%08h last %b",
                     m_data_o, m_last_o, mon_e.data, mon_e.last);
          end else begin
            $display("word %0d: 0x%08h last %b", n_words, m_data_o, m_last_o);
          end
        end
      end
      stalled   = !m_ready_i;
      held_data = m_data_o;
      held_last = m_last_o;
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] bytes;
    reset       = 1'b1;
    frame_a_i   = '0;
    frame_b_i   = '0;
    rdy_a_i     = 1'b0;
    rdy_b_i     = 1'b0;
    fec_a_i     = 1'b0;
    fec_b_i     = 1'b0;
    enable_i    = 1'b0;
    chan_mask_i = 2'b00;
    m_ready_i   = 1'b1;

    // Reset state
    cycle();
    cycle();
    reset = 1'b0;
    fc = 0;
    dc = 0;
    check_idle_zero("reset");

    // Both channels, always ready: 18 words, A header then B header
    frame_a_i = make_frame(32'hA5A5_0000);
    frame_b_i = make_frame(32'h5A5A_0000);
    capture(2'b11, 1'b1, 1'b1, 1'b1);
    drain(1'b0);
    check("busy_after_last", 32'(busy_o), 32'd0);
    check("frame_cnt_ab", 32'(frame_cnt_o), 32'(fc));
    check("drop_cnt_ab",  32'(drop_cnt_o),  32'd0);

    // B only, incrementing bytes, hand-computed words
    for (int i = 0; i < 32; i++) bytes[8*i +: 8] = 8'(i);
    frame_b_i = bytes[FRAME_W-1:0];
    for (int i = 0; i < 9; i++) sb.push_back({t3_exp[i], i == 8});
    capture(2'b10, 1'b0, 1'b1, 1'b0);
    drain(1'b0);
    check("frame_cnt_b", 32'(frame_cnt_o), 32'(fc));

    // Random back-pressure
    frame_a_i = make_frame(32'h0BAD_F00D);
    frame_b_i = make_frame(32'hC0DE_0001);
    capture(2'b11, 1'b1, 1'b1, 1'b1);
    drain(1'b1);

    // Continuous rdy: capture every 19 cycles, drops while busy
    cont(3);
    drain(1'b0);
    check("drop_cnt_cont", 32'(drop_cnt_o), 32'(dc));
    check("frame_cnt_cont", 32'(frame_cnt_o), 32'(fc));

    // Long run: drop counter saturates, frame counter wraps
    cont(60);
    drain(1'b0);
    check("drop_cnt_sat", 32'(drop_cnt_o), 32'(CNT_MAX));
    check("frame_cnt_wrap", 32'(frame_cnt_o), 32'(fc));

    // Reset while word 5 of channel A is presented
    frame_a_i = make_frame(32'h7777_0000);
    frame_b_i = make_frame(32'h8888_0000);
    capture(2'b11, 1'b1, 1'b1, 1'b1);
    repeat (5) cycle();
    check("words_before_reset", 32'(sb.size()), 32'd13);
    reset = 1'b1;
    cycle();
    fc = 0;
    dc = 0;
    check_idle_zero("midreset");
    sb.delete();
    reset = 1'b0;
    capture(2'b11, 1'b1, 1'b1, 1'b1);
    drain(1'b0);

    // FEC on three rdy cycles of channel A
    fec_a_i     = 1'b1;
    chan_mask_i = 2'b01;
    enable_i    = 1'b1;
    rdy_a_i     = 1'b1;
    push_pkt(2'b01, fc);
    repeat (3) cycle();
    rdy_a_i     = 1'b0;
    fec_a_i     = 1'b0;
    enable_i    = 1'b0;
    chan_mask_i = 2'b00;
    dc = dc + 2;
    drain(1'b0);
`ifdef SP3_FRAME_PACKER_FEC_CNT_EN
    check("fec_cnt_a", 32'(fec_cnt_a_o), 32'd3);
`else
    check("fec_cnt_a", 32'(fec_cnt_a_o), 32'd0);
`endif
    check("fec_cnt_b", 32'(fec_cnt_b_o), 32'd0);
    check("drop_cnt_fec", 32'(drop_cnt_o), 32'(dc));

    // enable_i low: rdy counts frames but nothing is captured
    chan_mask_i = 2'b11;
    rdy_a_i     = 1'b1;
    repeat (2) cycle();
    rdy_a_i     = 1'b0;
    chan_mask_i = 2'b00;
    repeat (20) cycle();
    check("busy_disabled", 32'(busy_o), 32'd0);
    check("frame_cnt_disabled", 32'(frame_cnt_o), 32'(fc));
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
